// File: rtl/fpu_mul_scheduler.sv
// fpu_mul_scheduler
// Round-robin front end that time-shares one non-pipelined, fixed-latency
// single-precision multiplier among N_REQ requesters. One operand pair is
// accepted at a time, the multiplier is started with a one-cycle pulse, the
// product is captured after LATENCY cycles and returned with the owner's tag.
//
// Optional build macro: FPU_MUL_SCHED_STATS_EN
//   When defined, adds stat_ops (completed result handshakes) and stat_wait
//   (cycles a request or result was left waiting). Both are 16-bit wrapping
//   counters cleared by reset.
//
// TAG_W must satisfy 2**TAG_W >= N_REQ; LATENCY must be at least 1.

module fpu_mul_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TAG_W   = 2,
    parameter int LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [TAG_W-1:0]      res_tag,
    output logic                  mul_start,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_res,
    output logic                  busy
`ifdef FPU_MUL_SCHED_STATS_EN
    ,
    output logic [15:0]           stat_ops,
    output logic [15:0]           stat_wait
`endif
);

    // Counter must be able to hold the value LATENCY itself.
    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [TAG_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [TAG_W-1:0]   tag_r;
    logic               res_valid_r;
    logic [31:0]        res_data_r;
    logic [TAG_W-1:0]   res_tag_r;
    logic               mul_start_r;
    logic [31:0]        mul_a_r;
    logic [31:0]        mul_b_r;
    logic               busy_r;

    logic [TAG_W-1:0]   lo_grant_s;
    logic [TAG_W-1:0]   hi_grant_s;
    logic               hi_found_s;
    logic               any_valid_s;
    logic [TAG_W-1:0]   grant_s;
    logic               idle_s;
    logic               accept_s;
    logic [31:0]        a_sel_s;
    logic [31:0]        b_sel_s;
    logic [N_REQ-1:0]   ready_s;
    logic [TAG_W-1:0]   rr_next_s;

    // Round-robin search: lowest valid index at or above rr_ptr, else lowest valid index overall.
    always_comb begin
        lo_grant_s  = {TAG_W{1'b0}};
        hi_grant_s  = {TAG_W{1'b0}};
        hi_found_s  = 1'b0;
        any_valid_s = 1'b0;
        // Descending scan so the final overwrite leaves the lowest matching index.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            lo_grant_s  = req_valid[i] ? TAG_W'(i) : lo_grant_s;
            hi_grant_s  = (req_valid[i] && (TAG_W'(i) >= rr_ptr_r)) ? TAG_W'(i) : hi_grant_s;
            hi_found_s  = hi_found_s | (req_valid[i] && (TAG_W'(i) >= rr_ptr_r));
            any_valid_s = any_valid_s | req_valid[i];
        end
        grant_s  = hi_found_s ? hi_grant_s : lo_grant_s;
        idle_s   = (state_r == ST_IDLE);
        accept_s = idle_s && any_valid_s;
        if (grant_s == TAG_W'(N_REQ - 1)) begin
            rr_next_s = {TAG_W{1'b0}};
        end else begin
            rr_next_s = grant_s + TAG_W'(1);
        end
    end

    // Operand mux for the granted requester and the one-hot ready vector.
    always_comb begin
        a_sel_s = 32'h0000_0000;
        b_sel_s = 32'h0000_0000;
        ready_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            a_sel_s    = (TAG_W'(i) == grant_s) ? req_a[32*i +: 32] : a_sel_s;
            b_sel_s    = (TAG_W'(i) == grant_s) ? req_b[32*i +: 32] : b_sel_s;
            // Gated by reset so ready reads zero while reset is held.
            ready_s[i] = accept_s && !reset && (TAG_W'(i) == grant_s);
        end
    end

    // Scheduler FSM: accept in IDLE, count out the multiplier latency in RUN, hold the result in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {TAG_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            tag_r       <= {TAG_W{1'b0}};
            res_valid_r <= 1'b0;
            res_data_r  <= 32'h0000_0000;
            res_tag_r   <= {TAG_W{1'b0}};
            mul_start_r <= 1'b0;
            mul_a_r     <= 32'h0000_0000;
            mul_b_r     <= 32'h0000_0000;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mul_a_r     <= a_sel_s;
                        mul_b_r     <= b_sel_s;
                        tag_r       <= grant_s;
                        rr_ptr_r    <= rr_next_s;
                        cnt_r       <= {CNT_W{1'b0}};
                        // Start pulse lands in the first RUN cycle (cnt == 0).
                        mul_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_RUN;
                    end else begin
                        mul_start_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    mul_start_r <= 1'b0;
                    if (cnt_r == CNT_W'(LATENCY)) begin
                        res_data_r  <= mul_res;
                        res_tag_r   <= tag_r;
                        res_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    mul_start_r <= 1'b0;
                    // No accept in the result-handshake cycle: IDLE is entered first.
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        res_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    res_valid_r <= 1'b0;
                    mul_start_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_tag   = res_tag_r;
    assign mul_start = mul_start_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign busy      = busy_r;

`ifdef FPU_MUL_SCHED_STATS_EN
    logic [15:0] stat_ops_r;
    logic [15:0] stat_wait_r;
    logic        done_s;

    assign done_s = (state_r == ST_DONE);

    // Activity counters: completed results, and cycles where work or a result sat waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ops_r  <= 16'h0000;
            stat_wait_r <= 16'h0000;
        end else begin
            if (done_s && res_ready) begin
                stat_ops_r <= stat_ops_r + 16'h0001;
            end else begin
                stat_ops_r <= stat_ops_r;
            end
            // The IDLE term never fires (any valid request is accepted) and is kept as a sanity aid.
            if ((idle_s && any_valid_s && !accept_s) || (done_s && res_valid_r && !res_ready)) begin
                stat_wait_r <= stat_wait_r + 16'h0001;
            end else begin
                stat_wait_r <= stat_wait_r;
            end
        end
    end

    assign stat_ops  = stat_ops_r;
    assign stat_wait = stat_wait_r;
`endif

endmodule

// File: doc/fpu_mul_scheduler.md
Name: fpu_mul_scheduler

Overview:
- Round-robin scheduler that shares one multi-cycle floating-point multiplier (single-precision, non-pipelined) among N_REQ requesters.
- Accepts one operand pair at a time via valid/ready and drives the multiplier's operand and start lines.
- Waits the fixed multiplier latency, captures the product, and returns it tagged with the requester index via valid/ready.
- Sits between client blocks (ALU sequencer, test harness) and the FPU multiplier datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TAG_W, 2, width of the requester tag; must satisfy 2**TAG_W >= N_REQ.
- LATENCY, 3, cycles from mul_start to a valid mul_res (>= 1).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester operand-valid.
- req_a  input  32*N_REQ  operand A, requester i at bits [32*i+31:32*i].
- req_b  input  32*N_REQ  operand B, same packing.
- req_ready  output  N_REQ  one-hot accept; a handshake occurs when req_valid[i] and req_ready[i] are both high.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  32  IEEE-754 product.
- res_tag  output  TAG_W  index of the requester that owns res_data.
- mul_start  output  1  one-cycle start pulse to the multiplier.
- mul_a  output  32  multiplier operand A, held stable while busy.
- mul_b  output  32  multiplier operand B, held stable while busy.
- mul_res  input  32  multiplier result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, rr_ptr=0, cnt=0. All outputs are 0: req_ready, res_valid, res_data, res_tag, mul_start, mul_a, mul_b, busy. Any in-flight operation is discarded with no result emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - grant = first index g scanning rr_ptr, rr_ptr+1, … mod N_REQ with req_valid[g]=1.
  - req_ready = one-hot(g), combinational, only when at least one request is valid; otherwise all zero.
  - On handshake: latch req_a[g] and req_b[g] into mul_a and mul_b, tag<=g, rr_ptr<=(g+1) mod N_REQ, cnt<=0, go to RUN.
- RUN:
  - req_ready=0.
  - mul_start=1 only in the first RUN cycle (cnt==0).
  - cnt increments each cycle.
  - When cnt==LATENCY: capture res_data<=mul_res and res_tag<=tag, go to DONE.
  - Handshake at cycle t gives mul_start in cycle t+1 and res_valid first high in cycle t+LATENCY+2.
- DONE:
  - res_valid=1; res_data and res_tag are held stable until res_ready.
  - On res_ready: go to IDLE with res_valid=0 in the next cycle.
  - New requests are not accepted in the same cycle as the result handshake.
- Maximum throughput: one operation per LATENCY+3 cycles.
- mul_a and mul_b keep their last values in IDLE and DONE. They change only on an accept.
- A requester dropping req_valid before it is granted is legal; it is simply skipped.
- Simultaneous requests: round-robin fairness. With all N_REQ requesting continuously, grants go 0,1,…,N_REQ-1,0,…
- rr_ptr wraps from N_REQ-1 to 0.
- res_ready asserted outside DONE is ignored.
- No arithmetic is performed here. Special values (0, inf, NaN) are passed through from mul_res unchanged.

Optional Feature:
- Macro: FPU_MUL_SCHED_STATS_EN.
- Defined: adds output stat_ops [15:0] and output stat_wait [15:0].
  - stat_ops counts completed result handshakes.
  - stat_wait counts cycles in IDLE where some req_valid is high but no accept occurs (always 0 by design; kept as an assertion aid). It also counts cycles in DONE with res_valid=1 and res_ready=0.
  - Both counters wrap 16'hFFFF to 0 and are cleared by reset.
- Undefined: neither port nor either counter exists; behaviour is otherwise identical.

Test Plan:
- Single request, LATENCY=3, model multiplier: req_valid=4'b0001, A=0x40000000, B=0x40400000, accept at cycle t. Required: mul_start at t+1; res_valid at t+5 with res_data=0x40C00000 and res_tag=0.
- All four requesting continuously, res_ready tied 1. Required: grant order 0,1,2,3,0; res_tag follows the same sequence; accepts spaced LATENCY+3=6 cycles apart.
- Back-pressure: res_ready=0 for 10 cycles after res_valid. Required: res_valid, res_data and res_tag are stable; req_ready stays 0; busy=1; completion occurs on the first cycle res_ready=1.
- Reset asserted 2 cycles after mul_start, requests 1 and 3 pending. Required: all outputs are 0 immediately (async). After release, the first grant goes to requester 1 (rr_ptr=0), and no stale result appears.
- Special values: A=0x00000000, B=0x7F800000 with model output 0x7F800001. Required: res_data=0x7F800001 unchanged; A=0xC0000000, B=0x3F800000 gives 0xC0000000.
- With FPU_MUL_SCHED_STATS_EN: 5 completions plus 7 cycles of res_ready back-pressure. Required: stat_ops=5, stat_wait=7; reset returns both to 0.
